// File: rtl/tt_um_addon_serial.sv
// Bit-serial add/sub/accumulate/saturate unit with a byte-wide load and readout port.
// Operands are loaded a byte at a time on wr edges. A single full adder then walks the
// bits LSB first, one per cycle. The result is read back a byte at a time on rd edges.
module tt_um_addon_serial #(
  parameter int unsigned WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned PW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StLoadA, StLoadB, StCalc, StDone} state_e;
  typedef enum logic [1:0] {OpAdd = 2'b00, OpSub = 2'b01, OpAcc = 2'b10, OpSat = 2'b11} op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [PW-1:0]    ptr_q, ptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             cy_q, cy_d, carry_q, carry_d, ovf_q, ovf_d;
  logic             wr_prev_q, wr_prev_d, rd_prev_q, rd_prev_d;

  logic wr_ev, rd_ev, clear;
  logic a_bit, b_bit, sum, cout;
  logic unused_ok;

  assign unused_ok = ^{ena, uio_in[7:5]};

  assign wr_ev = uio_in[0] & ~wr_prev_q;
  assign rd_ev = uio_in[1] & ~rd_prev_q;
  assign clear = uio_in[4];

  // Single full adder; SUB inverts B and starts with carry-in 1.
  assign a_bit = a_q[cnt_q];
  assign b_bit = b_q[cnt_q] ^ (op_q == OpSub);
  assign sum   = a_bit ^ b_bit ^ cy_q;
  assign cout  = (a_bit & b_bit) | (cy_q & (a_bit ^ b_bit));

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    ptr_d     = ptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    cy_d      = cy_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    wr_prev_d = uio_in[0];
    rd_prev_d = uio_in[1];
    if (clear) begin
      state_d   = StLoadA;
      a_d       = '0;
      b_d       = '0;
      res_d     = '0;
      ptr_d     = '0;
      rptr_d    = '0;
      cnt_d     = '0;
      op_d      = OpAdd;
      cy_d      = 1'b0;
      carry_d   = 1'b0;
      ovf_d     = 1'b0;
      wr_prev_d = 1'b1;
      rd_prev_d = 1'b1;
    end else begin
      unique case (state_q)
        StLoadA: begin
          if (wr_ev) begin
            a_d[8*ptr_q +: 8] = ui_in;
            if (ptr_q == PW'(NB - 1)) begin
              ptr_d   = '0;
              state_d = StLoadB;
            end else begin
              ptr_d = ptr_q + PW'(1);
            end
          end
        end
        StLoadB: begin
          if (wr_ev) begin
            b_d[8*ptr_q +: 8] = ui_in;
            if (ptr_q == PW'(NB - 1)) begin
              ptr_d   = '0;
              op_d    = uio_in[3:2];
              cnt_d   = '0;
              cy_d    = (uio_in[3:2] == OpSub);
              state_d = StCalc;
            end else begin
              ptr_d = ptr_q + PW'(1);
            end
          end
        end
        StCalc: begin
          res_d[cnt_q] = sum;
          cy_d         = cout;
          if (cnt_q == CW'(WIDTH - 1)) begin
            carry_d = cout;
            // Signed overflow is carry into the MSB differing from carry out of it.
            ovf_d   = (op_q == OpSat) ? cout : (cout ^ cy_q);
            if ((op_q == OpSat) && cout) res_d = '1;
            rptr_d  = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        StDone: begin
          if (wr_ev) begin
            if (uio_in[3:2] == OpAcc) begin
              a_d      = res_q;
              b_d      = '0;
              b_d[7:0] = ui_in;
              if (NB == 1) begin
                ptr_d   = '0;
                op_d    = OpAcc;
                cnt_d   = '0;
                cy_d    = 1'b0;
                state_d = StCalc;
              end else begin
                ptr_d   = PW'(1);
                state_d = StLoadB;
              end
            end else begin
              a_d      = '0;
              a_d[7:0] = ui_in;
              if (NB == 1) begin
                ptr_d   = '0;
                state_d = StLoadB;
              end else begin
                ptr_d   = PW'(1);
                state_d = StLoadA;
              end
            end
          end else if (rd_ev) begin
            rptr_d = (rptr_q == PW'(NB - 1)) ? '0 : rptr_q + PW'(1);
          end
        end
        default: state_d = StLoadA;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StLoadA;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      ptr_q     <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      op_q      <= OpAdd;
      cy_q      <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      wr_prev_q <= 1'b1;
      rd_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      ptr_q     <= ptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      cy_q      <= cy_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      wr_prev_q <= wr_prev_d;
      rd_prev_q <= rd_prev_d;
    end
  end

  // Output decode: result byte only while DONE, status on the upper nibble.
  always_comb begin
    uo_out  = (state_q == StDone) ? res_q[8*rptr_q +: 8] : 8'h00;
    uio_out = {ovf_q, carry_q, state_q == StDone, state_q == StCalc, 4'b0000};
    uio_oe  = 8'hF0;
  end

endmodule

// File: tb/tb_tt_um_addon_serial.sv
// Directed bench for tt_um_addon_serial (WIDTH=16) with a done-edge scoreboard monitor.
module tb_tt_um_addon_serial;

  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ACC = 2'b10, OP_SAT = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic       wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int total = 0;
  int bad = 0;
  logic [9:0] exp_q[$];  // {result low byte, carry, overflow}
  logic done_seen = 1'b0;

  assign uio_in = {3'b000, clr, op, rd, wr};

  always #5 clk = ~clk;

  tt_um_addon_serial #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: on each rising done, pop the expected entry and compare.
  always @(negedge clk) begin
    if (rst_n && uio_out[5] && !done_seen) begin
      if (exp_q.size() == 0) begin
        check("mon_unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("mon_byte0", {24'd0, uo_out}, {24'd0, e[9:2]});
        check("mon_carry", {31'd0, uio_out[6]}, {31'd0, e[1]});
        check("mon_ovf", {31'd0, uio_out[7]}, {31'd0, e[0]});
      end
    end
    done_seen = uio_out[5];
  end

  task automatic wr_byte(input logic [7:0] b, input logic [1:0] o);
    @(posedge clk); #1 ui_in = b; op = o; wr = 1'b1;
    @(posedge clk); #1 wr = 1'b0;
  endtask

  task automatic rd_pulse();
    @(posedge clk); #1 rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
  endtask

  // Bounded wait for done; optionally checks latency and busy duration.
  task automatic wait_done(input bit lat);
    int n = 0;
    int nb = 0;
    while (!uio_out[5] && n < 100) begin
      if (uio_out[4]) nb++;
      @(posedge clk); #1;
      n++;
    end
    check("done_reached", {31'd0, uio_out[5]}, 32'd1);
    if (lat) begin
      check("done_latency", n, 32'd16);
      check("busy_cycles", nb, 32'd16);
    end
  endtask

  task automatic read_result(input logic [15:0] r);
    check("rd_byte0", {24'd0, uo_out}, {24'd0, r[7:0]});
    rd_pulse();
    check("rd_byte1", {24'd0, uo_out}, {24'd0, r[15:8]});
    rd_pulse();
    check("rd_wrap", {24'd0, uo_out}, {24'd0, r[7:0]});
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o,
                        input logic [15:0] r, input logic c, input logic v, input bit poke);
    exp_q.push_back({r[7:0], c, v});
    wr_byte(a[7:0], o);
    wr_byte(a[15:8], o);
    wr_byte(b[7:0], o);
    wr_byte(b[15:8], o);
    if (poke) wr_byte(8'hAA, OP_ADD);  // must be ignored in CALC
    wait_done(!poke);
    read_result(r);
  endtask

  task automatic acc_op(input logic [15:0] b, input logic [15:0] r);
    exp_q.push_back({r[7:0], 1'b0, 1'b0});
    wr_byte(b[7:0], OP_ACC);
    wr_byte(b[15:8], OP_ACC);
    wait_done(1'b1);
    read_result(r);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_uo_out", {24'd0, uo_out}, 32'h0);
    check("reset_uio_out", {24'd0, uio_out}, 32'h0);
    check("uio_oe", {24'd0, uio_oe}, 32'hF0);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0F0F, OP_ADD, 16'h2143, 1'b0, 1'b0, 1'b0);
    // rd held for five cycles advances the pointer once.
    @(posedge clk); #1 rd = 1'b1;
    repeat (5) @(posedge clk);
    #1 rd = 1'b0;
    check("rd_held_once", {24'd0, uo_out}, 32'h21);
    // wr and rd together: wr wins, new load begins.
    @(posedge clk); #1 ui_in = 8'h55; op = OP_ADD; wr = 1'b1; rd = 1'b1;
    @(posedge clk); #1 wr = 1'b0; rd = 1'b0;
    check("wr_rd_done_low", {31'd0, uio_out[5]}, 32'd0);
    check("wr_rd_uo_zero", {24'd0, uo_out}, 32'h0);
    exp_q.push_back({8'h56, 1'b0, 1'b0});
    wr_byte(8'h00, OP_ADD);
    wr_byte(8'h01, OP_ADD);
    wr_byte(8'h00, OP_ADD);
    wait_done(1'b1);
    read_result(16'h0056);

    run_op(16'h0005, 16'h0007, OP_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b0, 1'b1, 1'b1);
    run_op(16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op(16'h0001, 16'h0002, OP_ADD, 16'h0003, 1'b0, 1'b0, 1'b0);
    acc_op(16'h0010, 16'h0013);
    acc_op(16'h0010, 16'h0023);
    run_op(16'hFFF0, 16'h0020, OP_SAT, 16'hFFFF, 1'b1, 1'b1, 1'b0);

    // Clear at CALC cycle 7 discards the operation and status.
    wr_byte(8'h11, OP_ADD);
    wr_byte(8'h11, OP_ADD);
    wr_byte(8'h22, OP_ADD);
    wr_byte(8'h22, OP_ADD);
    repeat (6) @(posedge clk);
    #1 check("calc_busy_before_clear", {31'd0, uio_out[4]}, 32'd1);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    check("clear_status", {24'd0, uio_out}, 32'h0);
    check("clear_uo_out", {24'd0, uo_out}, 32'h0);

    // wr held high through reset must not capture.
    @(posedge clk); #1 ui_in = 8'h77; wr = 1'b1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 wr = 1'b0;
    check("post_reset_status", {24'd0, uio_out}, 32'h0);
    run_op(16'h00FF, 16'h0001, OP_ADD, 16'h0100, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1 check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
